// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
// Also holds the pointer-width helper used by the top level and the queue.
package inst_fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] INST_NOP       = 32'h0000_0000;
    localparam int          FETCH_DEPTH    = 4;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: memory request/response, redirect, and instruction output.
// The master side is the fetch unit; the slave side is memory, branch unit and consumer.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit_queue.sv
// In-order fetch queue: entries are allocated at request, filled at response, popped at head.
// A flush invalidates every entry and collapses all three pointers onto the allocation pointer.
module fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int PW     = ptr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop_en,
    output logic [PW-1:0]     allocated,
    output logic [PW-1:0]     unfilled,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc
);
    localparam int IW = PW - 1;

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [PW-1:0]     head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;

    always_comb begin
        pc_d     = pc_q;
        data_d   = data_q;
        filled_d = filled_q;
        head_d   = head_q;
        alloc_d  = alloc_q;
        fill_d   = fill_q;
        if (flush) begin
            filled_d = '0;
            head_d   = alloc_q;
            fill_d   = alloc_q;
        end else begin
            // Allocation and fill never target the same slot: a fill needs an unfilled entry,
            // and allocation is blocked once every slot is taken.
            if (alloc_en) begin
                pc_d[alloc_q[IW-1:0]]     = alloc_pc;
                filled_d[alloc_q[IW-1:0]] = 1'b0;
                alloc_d                   = alloc_q + 1'b1;
            end
            if (fill_en) begin
                data_d[fill_q[IW-1:0]]   = fill_data;
                filled_d[fill_q[IW-1:0]] = 1'b1;
                fill_d                   = fill_q + 1'b1;
            end
            if (pop_en) begin
                head_d = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= DATA_W'(INST_NOP);
            end
            filled_q <= '0;
            head_q   <= '0;
            alloc_q  <= '0;
            fill_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            data_q   <= data_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
        end
    end

    assign allocated  = alloc_q - head_q;
    assign unfilled   = alloc_q - fill_q;
    assign head_valid = (head_q != fill_q) & filled_q[head_q[IW-1:0]];
    assign head_data  = data_q[head_q[IW-1:0]];
    assign head_pc    = pc_q[head_q[IW-1:0]];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC register, in-order memory requests, response drop counter
// after redirects, and the instruction queue that feeds the decoder.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter int                DEPTH    = FETCH_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    inst_fetch_unit_if.master  bus
);
    localparam int PW = ptr_w(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     drop_q, drop_d, drop_sum;
    logic [PW-1:0]     allocated, unfilled;
    logic              req_valid, fire, fill_en, pop, head_valid, rsp_take;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_pc;
    logic              unused_redirect_lsbs;

    // Requests are gated by reset so nothing is offered to memory while it is also in reset.
    assign req_valid = reset & ~bus.redirect_valid & (allocated < PW'(DEPTH));
    assign fire      = req_valid & bus.imem_req_ready;
    assign fill_en   = bus.imem_rsp_valid & (drop_q == '0) & (unfilled != '0) & ~bus.redirect_valid;
    assign pop       = bus.inst_valid & bus.inst_ready;
    assign drop_sum  = drop_q + unfilled;
    assign rsp_take  = bus.imem_rsp_valid & (drop_sum != '0);

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (bus.redirect_valid) begin
            // Every request still in flight must be discarded; a response arriving now counts.
            pc_d   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            drop_d = drop_sum - {{(PW-1){1'b0}}, rsp_take};
        end else begin
            if (fire) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            if (bus.imem_rsp_valid && drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .alloc_en   (fire),
        .alloc_pc   (pc_q),
        .fill_en    (fill_en),
        .fill_data  (bus.imem_rsp_data),
        .pop_en     (pop),
        .allocated  (allocated),
        .unfilled   (unfilled),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_pc    (head_pc)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = head_valid & ~bus.redirect_valid;
    assign bus.inst_data      = head_data;
    assign bus.inst_pc        = head_pc;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: behavioural variable-latency memory, request/pop logging,
// directed sequences plus a table of redirect vectors.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus();

    inst_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0040_0000),
        .DEPTH    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int mem_lat = 1;
    int cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mq[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_dat[$];
    int          fire_cyc[$];
    int          pop_cyc[$];

    typedef struct {
        int          lat;
        int          pre_fires;
        logic [31:0] redir_pc;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp_drop;
    } redir_vec_t;
    redir_vec_t vecs[5];

    function automatic logic [31:0] dexp(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: in-order, fixed latency, always ready; shares the DUT reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            cyc <= 0;
        end else begin
            if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back(mreq_t'{addr: bus.imem_req_addr, due: cyc + mem_lat});
                fire_log.push_back(bus.imem_req_addr);
                fire_cyc.push_back(cyc);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                pop_log.push_back(bus.inst_pc);
                pop_dat.push_back(bus.inst_data);
                pop_cyc.push_back(cyc);
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clock) begin
        if (reset && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rsp_data  <= dexp(mq[0].addr);
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_logs();
        fire_log.delete();
        fire_cyc.delete();
        pop_log.delete();
        pop_dat.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input int lat, input logic irdy);
        reset              = 1'b0;
        mem_lat            = lat;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = irdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step();
        step();
        clear_logs();
        reset = 1'b1;
    endtask

    task automatic wait_fires(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (fire_log.size() >= n) break;
            step();
        end
        chk(name, 32'(fire_log.size() >= n), 32'd1);
    endtask

    task automatic wait_pops(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (pop_log.size() >= n) break;
            step();
        end
        chk(name, 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic check_pop_data(input string name);
        for (int i = 0; i < pop_log.size(); i++) chk(name, pop_dat[i], dexp(pop_log[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;

        vecs[0] = '{lat: 3, pre_fires: 3, redir_pc: 32'h0040_0103,
                    exp0: 32'h0040_0100, exp1: 32'h0040_0104, exp_drop: 32'd2};
        vecs[1] = '{lat: 1, pre_fires: 5, redir_pc: 32'hFFFF_FFFC,
                    exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000, exp_drop: 32'd0};
        vecs[2] = '{lat: 3, pre_fires: 2, redir_pc: 32'h0000_1002,
                    exp0: 32'h0000_1000, exp1: 32'h0000_1004, exp_drop: 32'd2};
        vecs[3] = '{lat: 1, pre_fires: 1, redir_pc: 32'h1234_5679,
                    exp0: 32'h1234_5678, exp1: 32'h1234_567C, exp_drop: 32'd0};
        vecs[4] = '{lat: 2, pre_fires: 4, redir_pc: 32'h8000_0000,
                    exp0: 32'h8000_0000, exp1: 32'h8000_0004, exp_drop: 32'd1};

        // Reset state, then streaming at latency 1.
        do_reset(1, 1'b1);
        reset = 1'b0;
        step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        clear_logs();
        reset = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 6; i++) begin
            chk("stream_fire_addr", fire_log[i], 32'h0040_0000 + 32'(4 * i));
            chk("stream_inst_pc", pop_log[i], 32'h0040_0000 + 32'(4 * i));
        end
        chk("stream_first_latency", 32'(pop_cyc[0] - fire_cyc[0]), 32'd2);
        chk("stream_throughput", 32'(pop_cyc[5] - pop_cyc[0]), 32'd5);
        check_pop_data("stream_inst_data");

        // Queue full with consumer stalled; one pop frees one fire.
        do_reset(1, 1'b0);
        repeat (12) step();
        chk("full_fire_count", 32'(fire_log.size()), 32'd4);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("full_head_valid", 32'(bus.inst_valid), 32'd1);
        chk("full_head_pc", bus.inst_pc, 32'h0040_0000);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("full_pop_count", 32'(pop_log.size()), 32'd1);
        chk("full_req_after_pop", 32'(bus.imem_req_valid), 32'd1);
        chk("full_req_addr", bus.imem_req_addr, 32'h0040_0010);
        step();
        chk("full_fire_count2", 32'(fire_log.size()), 32'd5);
        chk("full_fire_addr", fire_log[4], 32'h0040_0010);
        chk("full_new_head_pc", bus.inst_pc, 32'h0040_0004);
        check_pop_data("full_inst_data");

        // Redirect vectors: alignment, wrap, drop count, no stale instruction, no pop.
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].lat, 1'b1);
            wait_fires(vecs[v].pre_fires, "redir_prefire_timeout");
            k = fire_log.size();
            p = pop_log.size();
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = vecs[v].redir_pc;
            #1;
            chk("redir_req_blocked", 32'(bus.imem_req_valid), 32'd0);
            chk("redir_inst_blocked", 32'(bus.inst_valid), 32'd0);
            step();
            bus.redirect_valid = 1'b0;
            chk("redir_drop_cnt", 32'(dut.drop_q), vecs[v].exp_drop);
            chk("redir_no_pop", 32'(pop_log.size()), 32'(p));
            chk("redir_no_fire", 32'(fire_log.size()), 32'(k));
            chk("redir_next_addr", bus.imem_req_addr, vecs[v].exp0);
            wait_pops(p + 2, "redir_pop_timeout");
            chk("redir_fire0", fire_log[k], vecs[v].exp0);
            chk("redir_fire1", fire_log[k + 1], vecs[v].exp1);
            chk("redir_first_inst_pc", pop_log[p], vecs[v].exp0);
            chk("redir_second_inst_pc", pop_log[p + 1], vecs[v].exp1);
            check_pop_data("redir_inst_data");
        end

        // Back-to-back redirects: only the second target is fetched.
        do_reset(2, 1'b1);
        wait_fires(3, "b2b_prefire_timeout");
        k = fire_log.size();
        p = pop_log.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2000;
        step();
        bus.redirect_pc    = 32'h0000_3000;
        step();
        bus.redirect_valid = 1'b0;
        wait_pops(p + 1, "b2b_pop_timeout");
        chk("b2b_fire0", fire_log[k], 32'h0000_3000);
        chk("b2b_first_inst_pc", pop_log[p], 32'h0000_3000);

        // Reset mid-operation with two filled entries and two requests in flight.
        do_reset(2, 1'b0);
        wait_fires(4, "midrst_prefire_timeout");
        chk("midrst_pre_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("midrst_pre_inst_pc", bus.inst_pc, 32'h0040_0000);
        reset = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("midrst_inst_pc", bus.inst_pc, 32'd0);
        bus.inst_ready = 1'b1;
        step();
        step();
        clear_logs();
        reset = 1'b1;
        wait_pops(1, "midrst_pop_timeout");
        chk("midrst_first_fire", fire_log[0], FETCH_RESET_PC);
        chk("midrst_first_inst_pc", pop_log[0], FETCH_RESET_PC);
        check_pop_data("midrst_inst_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
